// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: one-cycle ADD/SUB/AND, iterative shift-add MUL,
// registered result with a completed-response counter.
module alu_seq_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         ctrl,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int RW = 2 * WIDTH;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [IW-1:0]    iter;
    logic [RW-1:0]    partial;

    // b_q doubles as the multiplier shift register during MUL
    assign partial    = acc + (b_q[0] ? mcand : '0);
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            result   <= '0;
            op_count <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc      <= '0;
            mcand    <= '0;
            iter     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= ctrl;
                        acc   <= '0;
                        mcand <= RW'(A);
                        iter  <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    unique case (op_q)
                        2'b00: begin
                            result <= RW'(a_q) + RW'(b_q);
                            state  <= DONE;
                        end
                        2'b01: begin
                            result <= RW'(a_q) - RW'(b_q);
                            state  <= DONE;
                        end
                        2'b11: begin
                            result <= RW'(a_q & b_q);
                            state  <= DONE;
                        end
                        default: begin
                            acc   <= partial;
                            mcand <= mcand << 1;
                            b_q   <= b_q >> 1;
                            iter  <= iter + 1'b1;
                            if (iter == IW'(WIDTH - 1)) begin
                                result <= partial;
                                state  <= DONE;
                            end
                        end
                    endcase
                end
                DONE: begin
                    if (resp_ready) begin
                        op_count <= op_count + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] ctrl;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] result;
    logic       busy;
    logic [7:0] op_count;

    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt;
    int         n_pass = 0;
    int         n_total = 0;

    alu_seq_unit #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .A         (A),
        .B         (B),
        .ctrl      (ctrl),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .result    (result),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("unexpected_resp", 32'(resp_valid), 0);
            else check("result", 32'(result), 32'(exp_q.pop_front()));
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] c, input logic [7:0] e,
                         input int lat);
        int n;
        @(posedge clk); #1;
        check("req_ready_idle", 32'(req_ready), 1);
        A = a; B = b; ctrl = c;
        req_valid = 1'b1; resp_ready = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; A = ~a; B = ~b; ctrl = ~c;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check("valid_drop", 32'(resp_valid), 0);
        check("op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic [7:0] e;
        int         lat;
    } vec_t;

    vec_t vecs[7] = '{
        '{4'd6,  4'd3,  2'b00, 8'h09, 1},
        '{4'd6,  4'd3,  2'b01, 8'h03, 1},
        '{4'd3,  4'd6,  2'b01, 8'hFD, 1},
        '{4'd6,  4'd3,  2'b11, 8'h02, 1},
        '{4'd6,  4'd3,  2'b10, 8'h12, 4},
        '{4'd15, 4'd15, 2'b10, 8'hE1, 4},
        '{4'd0,  4'd15, 2'b10, 8'h00, 4}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        A = '0; B = '0; ctrl = '0; exp_cnt = '0;
        #1;
        check("rst_result", 32'(result), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_op_count", 32'(op_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rel_req_ready", 32'(req_ready), 1);

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, vecs[i].lat);

        // backpressure with a held, changing request
        @(posedge clk); #1;
        A = 4'd6; B = 4'd3; ctrl = 2'b10;
        req_valid = 1'b1; resp_ready = 1'b0;
        exp_q.push_back(8'h12);
        @(posedge clk); #1;
        A = 4'd15; B = 4'd15; ctrl = 2'b00;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", 32'(n), 4);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_result", 32'(result), 32'h12);
            check("bp_valid", 32'(resp_valid), 1);
            check("bp_req_ready", 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        exp_q.push_back(8'h1E);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check("bp_hs_valid", 32'(resp_valid), 0);
        check("bp_hs_req_ready", 32'(req_ready), 1);
        check("bp_hs_count", 32'(op_count), 32'(exp_cnt));
        @(posedge clk); #1;
        check("bp_next_busy", 32'(busy), 1);
        check("bp_next_req_ready", 32'(req_ready), 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_next_valid", 32'(resp_valid), 1);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check("bp_next_count", 32'(op_count), 32'(exp_cnt));

        // reset two cycles into a multiply
        @(posedge clk); #1;
        A = 4'd7; B = 4'd5; ctrl = 2'b10;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_result", 32'(result), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(resp_valid), 0);
        check("mid_rst_count", 32'(op_count), 0);
        exp_cnt = '0;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | resp_valid;
        end
        check("mid_rst_no_resp", 32'(seen), 0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            issue(iv[3:0], iv[7:4], 2'b00, 8'(iv[3:0]) + 8'(iv[7:4]), 1);
        end
        check("wrap_count", 32'(op_count), 0);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
